// File: rtl/led_channel_sequencer_pkg.sv
// Shared LED channel mode encodings, used by the sequencer, the system top
// and the control logic that issues configuration writes.
package led_channel_sequencer_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PULSE = 2'd3
    } led_mode_e;

    function automatic logic mode_is_active(input led_mode_e m);
        return (m == MODE_BLINK) || (m == MODE_PULSE);
    endfunction

endpackage

// File: rtl/led_channel_sequencer_tick_prescaler.sv
// Free-running prescaler: pre_cnt wraps 0..PRESCALE-1, tick decoded from the
// registered count so it is a clean one-clock pulse every PRESCALE clocks.
module tick_prescaler #(
    parameter int unsigned PRESCALE = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] pre_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt <= '0;
        end else if (pre_cnt == LAST) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + CW'(1);
        end
    end

    assign tick = (pre_cnt == LAST);

endmodule

// File: rtl/led_channel_sequencer.sv
// N_CH independently configured LED channels (off/on/blink/one-shot pulse)
// sharing one tick prescaler; periods are counted in ticks.
module led_channel_sequencer
    import led_channel_sequencer_pkg::*;
#(
    parameter  int unsigned CLK_FREQ = 50000000,
    parameter  int unsigned TICK_HZ  = 1000,
    parameter  int unsigned N_CH     = 4,
    parameter  int unsigned PW       = 16,
    localparam int unsigned CHW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CHW-1:0]    cfg_ch,
    input  logic [MODE_W-1:0] cfg_mode,
    input  logic [PW-1:0]     cfg_period,
    output logic              tick,
    output logic [N_CH-1:0]   led,
    output logic [N_CH-1:0]   active
);

    localparam int unsigned PRESCALE = CLK_FREQ / TICK_HZ;

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        led_mode_e     mode;
        logic [PW-1:0] period;
        logic [PW-1:0] cnt;
        logic          led_r;
        logic          wr_hit;
        logic          at_end;
        led_mode_e     wr_mode;

        // Out-of-range channel numbers match no instance, so they are dropped here.
        assign wr_hit  = cfg_we && (cfg_ch == CHW'(i));
        assign wr_mode = led_mode_e'(cfg_mode);
        assign at_end  = (cnt == period - PW'(1));

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                mode   <= MODE_OFF;
                period <= PW'(1);
                cnt    <= '0;
                led_r  <= 1'b0;
            end else if (wr_hit) begin
                // A write wins over a coincident tick and restarts the channel.
                mode   <= wr_mode;
                period <= (cfg_period == '0) ? PW'(1) : cfg_period;
                cnt    <= '0;
                led_r  <= (wr_mode != MODE_OFF);
            end else if (tick) begin
                unique case (mode)
                    MODE_BLINK: begin
                        if (at_end) begin
                            cnt   <= '0;
                            led_r <= ~led_r;
                        end else begin
                            cnt <= cnt + PW'(1);
                        end
                    end
                    MODE_PULSE: begin
                        if (at_end) begin
                            cnt   <= '0;
                            led_r <= 1'b0;
                            mode  <= MODE_OFF;
                        end else begin
                            cnt <= cnt + PW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end

        assign led[i]    = led_r;
        assign active[i] = mode_is_active(mode);
    end

endmodule

// File: tb/tb_led_channel_sequencer.sv
// Scoreboard bench for led_channel_sequencer: a countdown reference model
// pushes expected {tick, led, active} per edge; the negedge checker pops them.
module tb_led_channel_sequencer;

    localparam int unsigned CLK_FREQ = 1000;
    localparam int unsigned TICK_HZ  = 100;
    localparam int unsigned PRESCALE = CLK_FREQ / TICK_HZ;
    localparam int unsigned N_CH     = 3;
    localparam int unsigned PW       = 8;
    localparam int unsigned CHW      = 2;

    localparam int M_OFF   = 0;
    localparam int M_ON    = 1;
    localparam int M_BLINK = 2;
    localparam int M_PULSE = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_we;
    logic [CHW-1:0]  cfg_ch;
    logic [1:0]      cfg_mode;
    logic [PW-1:0]   cfg_period;
    logic            tick;
    logic [N_CH-1:0] led;
    logic [N_CH-1:0] active;

    led_channel_sequencer #(
        .CLK_FREQ(CLK_FREQ),
        .TICK_HZ (TICK_HZ),
        .N_CH    (N_CH),
        .PW      (PW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_mode  (cfg_mode),
        .cfg_period(cfg_period),
        .tick      (tick),
        .led       (led),
        .active    (active)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    typedef struct packed {
        logic            tick;
        logic [N_CH-1:0] led;
        logic [N_CH-1:0] act;
    } exp_t;

    exp_t sb[$];

    // Reference model: ticks-remaining countdown per channel.
    int unsigned     m_pre;
    int              m_mode [N_CH];
    int unsigned     m_per  [N_CH];
    int unsigned     m_left [N_CH];
    logic [N_CH-1:0] m_led;

    task automatic model_reset();
        m_pre = 0;
        m_led = '0;
        for (int c = 0; c < N_CH; c++) begin
            m_mode[c] = M_OFF;
            m_per[c]  = 1;
            m_left[c] = 1;
        end
        sb.delete();
    endtask

    task automatic model_step();
        bit   tk;
        exp_t e;
        tk    = (m_pre == PRESCALE - 1);
        m_pre = tk ? 0 : m_pre + 1;
        for (int c = 0; c < N_CH; c++) begin
            if (cfg_we && (int'(cfg_ch) == c)) begin
                m_mode[c] = int'(cfg_mode);
                m_per[c]  = (cfg_period == 0) ? 1 : int'(cfg_period);
                m_left[c] = m_per[c];
                m_led[c]  = (int'(cfg_mode) != M_OFF);
            end else if (tk && (m_mode[c] == M_BLINK || m_mode[c] == M_PULSE)) begin
                m_left[c] = m_left[c] - 1;
                if (m_left[c] == 0) begin
                    if (m_mode[c] == M_BLINK) begin
                        m_led[c]  = ~m_led[c];
                        m_left[c] = m_per[c];
                    end else begin
                        m_led[c]  = 1'b0;
                        m_mode[c] = M_OFF;
                    end
                end
            end
        end
        e.tick = (m_pre == PRESCALE - 1);
        e.led  = m_led;
        for (int c = 0; c < N_CH; c++)
            e.act[c] = (m_mode[c] == M_BLINK || m_mode[c] == M_PULSE);
        sb.push_back(e);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else      model_step();
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_eq("tick",   32'(tick),   32'(e.tick));
                check_eq("led",    32'(led),    32'(e.led));
                check_eq("active", 32'(active), 32'(e.act));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_wr(input int ch, input int mode, input int per);
        cfg_we     = 1'b1;
        cfg_ch     = CHW'(ch);
        cfg_mode   = 2'(mode);
        cfg_period = PW'(per);
        @(negedge clk);
        #2 cfg_we = 1'b0;
    endtask

    task automatic wr(input int ch, input int mode, input int per);
        @(negedge clk);
        #2 drive_wr(ch, mode, per);
    endtask

    task automatic wait_first_tick(output int n);
        n = -1;
        for (int k = 1; k <= 50; k++) begin
            @(posedge clk);
            #1;
            if (tick === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int n;
        rst        = 1'b0;
        cfg_we     = 1'b0;
        cfg_ch     = '0;
        cfg_mode   = '0;
        cfg_period = '0;

        idle(3);
        #1;
        check_eq("rst_led",    32'(led),    32'(0));
        check_eq("rst_active", 32'(active), 32'(0));
        check_eq("rst_tick",   32'(tick),   32'(0));
        #1 rst = 1'b1;

        wait_first_tick(n);
        check_eq("first_tick_edge", n, 9);
        idle(25);

        wr(1, M_BLINK, 3);
        idle(100);

        wr(2, M_PULSE, 2);
        idle(60);

        wr(0, M_BLINK, 0);
        idle(40);

        // ON write landing on the tick edge while ch1 is blinking
        n = 0;
        while (m_pre != PRESCALE - 1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("tick_align_found", 32'(m_pre), 32'(PRESCALE - 1));
        #2 drive_wr(1, M_ON, 5);
        idle(30);

        wr(3, M_BLINK, 5);
        idle(30);

        wr(0, M_BLINK, 2);
        wr(2, M_PULSE, 4);
        idle(27);

        @(negedge clk);
        #3 rst = 1'b0;
        #1;
        check_eq("async_rst_led",    32'(led),    32'(0));
        check_eq("async_rst_active", 32'(active), 32'(0));
        check_eq("async_rst_tick",   32'(tick),   32'(0));
        idle(3);
        #2 rst = 1'b1;

        wait_first_tick(n);
        check_eq("first_tick_edge_2", n, 9);
        idle(20);
        wr(1, M_BLINK, 1);
        idle(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_channel_sequencer.md
# led_channel_sequencer

Parametrised multi-channel LED driver. It generalises the single fixed-rate blinking LED into N_CH independently configured channels. Each channel has a mode (off, on, blink, one-shot pulse) and a period counted in ticks of a shared prescaler. The block sits between the system top-level's control logic (configuration writes) and the board LED pins.

## Interface
- CLK_FREQ, 50000000, input clock frequency in Hz
- TICK_HZ, 1000, shared tick rate; PRESCALE = CLK_FREQ/TICK_HZ, must be ≥ 2
- N_CH, 4, number of LED channels, ≥ 1
- PW, 16, width of the period and count registers
- CHW (derived), max(1, clog2(N_CH)), channel-select width

- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- cfg_we  in  1  configuration write strobe, one clk per write
- cfg_ch  in  CHW  target channel
- cfg_mode  in  2  0=OFF, 1=ON, 2=BLINK, 3=PULSE
- cfg_period  in  PW  period in ticks
- tick  out  1  one-clk pulse at TICK_HZ, exported for other blocks
- led  out  N_CH  registered LED drive, bit i = channel i
- active  out  N_CH  bit i high while channel i is in BLINK or PULSE

## Operation
- Prescaler `pre_cnt` counts 0..PRESCALE-1 and wraps to 0.
  - `tick` = (pre_cnt == PRESCALE-1), decoded from the registered count.
- Per-channel state: `mode` (2 b), `period` (PW), `cnt` (PW), `led` (1 b).
- Configuration write (cfg_we=1 and cfg_ch < N_CH), applied at that edge:
  - mode ← cfg_mode.
  - period ← cfg_period, except 0 is stored as 1.
  - cnt ← 0.
  - led ← 0 for OFF, 1 for ON, BLINK and PULSE.
- A write with cfg_ch ≥ N_CH is ignored with no side effects.
- OFF and ON: led holds its value; cnt is frozen.
- BLINK, on each tick edge:
  - if cnt == period-1: cnt ← 0 and led toggles;
  - else cnt ← cnt+1.
  - Result: led stays in each state for `period` ticks.
- PULSE, on each tick edge:
  - if cnt == period-1: led ← 0, mode ← OFF, cnt ← 0;
  - else cnt ← cnt+1.
  - Result: led stays high for exactly `period` ticks, then the channel self-disables.
- active[i] = (mode == BLINK) or (mode == PULSE).
- Simultaneous write and tick on the same channel: the write wins and the tick is discarded for that channel. All other channels process the tick normally.
- A write to a running channel restarts it from cnt=0 with the new settings; there is no carry-over.
- cnt is compared only against period-1 and never exceeds it, so there is no wrap hazard.

## Timing
- Reset asserted (rst=0): immediately and asynchronously, pre_cnt=0, all mode=OFF, period=1, cnt=0, led=0, active=0, and tick=0 (tick is decoded from pre_cnt=0).
- After reset release, the first tick occurs PRESCALE-1 clocks after the first active edge, then every PRESCALE clocks.
- Write latency: led and active reflect a write one clk after the edge that samples cfg_we.
- Tick latency: led changes at the same edge at which tick is high. No extra pipeline stage.
- Writes are always accepted, one per clk, with no backpressure.

## Structure
- Shared package: mode constants (MODE_OFF, MODE_ON, MODE_BLINK, MODE_PULSE) and the 2-bit mode width. The system top and the control logic use the same encodings.
- Sub-module `tick_prescaler`:
  - parameter PRESCALE; ports clk, rst, tick;
  - reusable by other timing blocks.
- Channels are a generate loop of identical per-channel logic inside led_channel_sequencer. No separate module for them.

## Test plan
Bench uses CLK_FREQ=1000, TICK_HZ=100 (PRESCALE=10), N_CH=3, PW=8.

- Reset release, no writes → led=000, active=000; tick high at clk 9, 19, 29, …
- Write ch1 BLINK period=3 → led[1]=1 the next clk; led[1] toggles every 30 clk; active[1]=1; led[0], led[2] stay 0.
- Write ch2 PULSE period=2 → led[2]=1 for exactly 2 ticks (20 clk aligned to ticks), then led[2]=0 and active[2]=0; a later tick does not re-light it.
- Write ch0 BLINK period=0 → led[0] toggles on every tick, i.e. same as period=1.
- Write ch1 ON in the same clk as a tick while ch1 is blinking → led[1]=1 and held. Write with cfg_ch=3 → no channel changes.
- Drive rst=0 mid-blink, between clock edges → led=000 and active=000 before the next edge. After release, restart matches the reset-release scenario.
